eip_sequencer: RTL

EIP_SEQUENCER -- requirements
Module: eip_sequencer

---
 rtl/eip_sequencer_pkg.sv | 16 +
 rtl/eip_ras.sv | 52 +++++
 rtl/eip_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/eip_sequencer_pkg.sv
// Shared op-code and state encodings for the instruction-pointer sequencer.
package eip_sequencer_pkg;

   localparam logic [2:0] OP_ADV  = 3'd0;
   localparam logic [2:0] OP_JMP  = 3'd1;
   localparam logic [2:0] OP_JREL = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;
   localparam logic [2:0] OP_HALT = 3'd5;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } seq_state_t;

endpackage

// File: rtl/eip_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module eip_ras #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [ADDR_W-1:0]          push_addr,
   output logic [ADDR_W-1:0]          top,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  ptr;

   // ptr is the next write slot, so the top of stack sits just below it
   assign top   = mem[ptr - PTR_ONE];
   assign full  = (count == CNT_MAX);
   assign empty = (count == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr   <= '0;
         count <= '0;
      end else if (clear) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         ptr <= ptr + PTR_ONE;
         if (!full) count <= count + CNT_ONE;
      end else if (pop && !empty) begin
         ptr   <= ptr - PTR_ONE;
         count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (push && !clear) mem[ptr] <= push_addr;
   end

endmodule

// File: rtl/eip_sequencer.sv
// Instruction-pointer sequencer: decodes ADV/JMP/JREL/CALL/RET/HALT, owns eip and run state.
module eip_sequencer
   import eip_sequencer_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int                RAS_DEPTH = 4,
   parameter int                LEN_W     = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [LEN_W-1:0]  insn_len,
   input  logic [ADDR_W-1:0] target,
   input  logic              restart,
   input  logic              clear_flags,
   output logic [ADDR_W-1:0] eip,
   output logic              err,
   output logic              ras_ovf,
   output logic              ras_unf,
   output logic              halted
);

   localparam int CNT_W = $clog2(RAS_DEPTH+1);

   seq_state_t        state;
   logic              accept, len_zero, restart_go;
   logic [ADDR_W-1:0] seq_addr, eip_nxt, ras_top;
   logic              push, pop, bad, set_ovf, set_unf, go_halt;
   logic              ras_full, ras_empty;
   logic [CNT_W-1:0]  ras_count;

   assign cmd_ready  = (state == ST_RUN);
   assign halted     = (state == ST_HALTED);
   assign accept     = cmd_valid && cmd_ready;
   assign len_zero   = (insn_len == '0);
   assign seq_addr   = eip + ADDR_W'(insn_len);
   assign restart_go = halted && restart;

   always_comb begin
      eip_nxt = eip;
      push    = 1'b0;
      pop     = 1'b0;
      bad     = 1'b0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      go_halt = 1'b0;
      if (accept) begin
         case (cmd_op)
            OP_ADV:  if (len_zero) bad = 1'b1; else eip_nxt = seq_addr;
            OP_JMP:  eip_nxt = target;
            OP_JREL: if (len_zero) bad = 1'b1; else eip_nxt = seq_addr + target;
            OP_CALL: begin
               if (len_zero) bad = 1'b1;
               else begin
                  push    = 1'b1;
                  set_ovf = ras_full;
                  eip_nxt = target;
               end
            end
            OP_RET: begin
               if (ras_empty) begin
                  bad     = 1'b1;
                  set_unf = 1'b1;
               end else begin
                  pop     = 1'b1;
                  eip_nxt = ras_top;
               end
            end
            OP_HALT: begin
               if (len_zero) bad = 1'b1;
               else begin
                  eip_nxt = seq_addr;
                  go_halt = 1'b1;
               end
            end
            default: bad = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         eip     <= RESET_VEC;
         state   <= ST_RUN;
         err     <= 1'b0;
         ras_ovf <= 1'b0;
         ras_unf <= 1'b0;
      end else begin
         err     <= bad;
         // a set in the same cycle as clear_flags wins
         ras_ovf <= set_ovf | (ras_ovf & ~clear_flags);
         ras_unf <= set_unf | (ras_unf & ~clear_flags);
         if (restart_go) begin
            eip   <= RESET_VEC;
            state <= ST_RUN;
         end else begin
            eip <= eip_nxt;
            if (go_halt) state <= ST_HALTED;
         end
      end
   end

   eip_ras #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clock     (clock),
      .reset     (reset),
      .clear     (restart_go),
      .push      (push),
      .pop       (pop),
      .push_addr (seq_addr),
      .top       (ras_top),
      .count     (ras_count),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   count_in_range: assert property (@(posedge clock) disable iff (!reset)
      ras_count <= CNT_W'(RAS_DEPTH));

endmodule
